// File: rtl/prbs_rx_chk_if.sv
// Link-side signal bundle for the PRBS-31 receive checker.
// BIT_ERR_CNT is carried only when PRBS_RX_BITERR_EN is defined.
interface prbs_rx_chk_if;
  logic        en;
  logic [47:0] prbs_in;
  logic        clr_cnt;
  logic        lock;
  logic        err;
  logic [31:0] word_cnt;
  logic [15:0] err_cnt;
`ifdef PRBS_RX_BITERR_EN
  logic [23:0] bit_err_cnt;

  modport master (output en, prbs_in, clr_cnt,
                  input  lock, err, word_cnt, err_cnt, bit_err_cnt);
  modport slave  (input  en, prbs_in, clr_cnt,
                  output lock, err, word_cnt, err_cnt, bit_err_cnt);
`else
  modport master (output en, prbs_in, clr_cnt,
                  input  lock, err, word_cnt, err_cnt);
  modport slave  (input  en, prbs_in, clr_cnt,
                  output lock, err, word_cnt, err_cnt);
`endif
endinterface

// File: rtl/prbs_rx_chk.sv
// Self-synchronizing PRBS-31 (x^31+x^28+1) checker for a 48-bit parallel link.
// Define PRBS_RX_BITERR_EN to add the per-bit error popcount and BIT_ERR_CNT.
module prbs_rx_chk #(
  parameter int LOCK_CNT   = 8,
  parameter int UNLOCK_CNT = 4
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  prbs_rx_chk_if.slave  bus
);

  localparam logic [7:0] LOCK_TGT   = 8'(LOCK_CNT);
  localparam logic [7:0] UNLOCK_TGT = 8'(UNLOCK_CNT);

  typedef enum logic [1:0] {ST_SEED, ST_ACQ, ST_LOCKED} state_e;

  state_e      fsm_q, fsm_d;
  logic [30:0] seed_q, seed_d;
  logic [7:0]  good_q, good_d;
  logic [7:0]  bad_q, bad_d;
  logic        lock_q, lock_d;
  logic        err_q, err_d;
  logic [31:0] wcnt_q, wcnt_d;
  logic [15:0] ecnt_q, ecnt_d;
  logic        w_inc, e_inc;
  logic [47:0] pred;
  logic        match;

  // seed_q[30] is the oldest bit; ext[78:48] is the state, ext[47:0] the next word.
  always_comb begin : predict
    logic [78:0] ext;
    ext = {seed_q, 48'd0};
    for (int k = 47; k >= 0; k--) begin
      ext[k] = ext[k+31] ^ ext[k+28];
    end
    pred = ext[47:0];
  end

  assign match = (bus.prbs_in == pred);

`ifdef PRBS_RX_BITERR_EN
  logic [5:0]  pop;
  logic [5:0]  b_add;
  logic [23:0] becnt_q, becnt_d;
  logic [24:0] bsum;
  logic [47:0] diff;

  always_comb begin
    diff = bus.prbs_in ^ pred;
    pop  = 6'd0;
    for (int i = 0; i < 48; i++) begin
      pop = pop + {5'd0, diff[i]};
    end
  end
`endif

  always_comb begin
    fsm_d  = fsm_q;
    seed_d = seed_q;
    good_d = good_q;
    bad_d  = bad_q;
    lock_d = lock_q;
    err_d  = 1'b0;
    w_inc  = 1'b0;
    e_inc  = 1'b0;
`ifdef PRBS_RX_BITERR_EN
    b_add  = 6'd0;
`endif
    if (bus.en) begin
      case (fsm_q)
        ST_SEED: begin
          seed_d = bus.prbs_in[30:0];
          good_d = 8'd0;
          fsm_d  = ST_ACQ;
        end
        ST_ACQ: begin
          if (match) begin
            good_d = good_q + 8'd1;
            seed_d = pred[30:0];
            if (good_d == LOCK_TGT) begin
              fsm_d  = ST_LOCKED;
              bad_d  = 8'd0;
              lock_d = 1'b1;
            end
          end else begin
            seed_d = bus.prbs_in[30:0];
            good_d = 8'd0;
          end
        end
        ST_LOCKED: begin
          // Predictor free-runs so received errors never corrupt it.
          seed_d = pred[30:0];
          w_inc  = 1'b1;
          if (match) begin
            bad_d = 8'd0;
          end else begin
            err_d = 1'b1;
            e_inc = 1'b1;
            bad_d = bad_q + 8'd1;
`ifdef PRBS_RX_BITERR_EN
            b_add = pop;
`endif
            if (bad_d == UNLOCK_TGT) begin
              fsm_d  = ST_ACQ;
              seed_d = bus.prbs_in[30:0];
              good_d = 8'd0;
              lock_d = 1'b0;
            end
          end
        end
        default: fsm_d = ST_SEED;
      endcase
    end
  end

  // Clear wins over a same-cycle increment; all counters saturate.
  always_comb begin
    wcnt_d = wcnt_q;
    ecnt_d = ecnt_q;
    if (bus.clr_cnt) begin
      wcnt_d = 32'd0;
      ecnt_d = 16'd0;
    end else begin
      if (w_inc && (wcnt_q != 32'hFFFF_FFFF)) wcnt_d = wcnt_q + 32'd1;
      if (e_inc && (ecnt_q != 16'hFFFF))      ecnt_d = ecnt_q + 16'd1;
    end
  end

`ifdef PRBS_RX_BITERR_EN
  always_comb begin
    bsum = {1'b0, becnt_q} + {19'd0, b_add};
    if (bus.clr_cnt)  becnt_d = 24'd0;
    else if (bsum[24]) becnt_d = 24'hFF_FFFF;
    else              becnt_d = bsum[23:0];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) becnt_q <= 24'd0;
    else          becnt_q <= becnt_d;
  end

  assign bus.bit_err_cnt = becnt_q;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fsm_q  <= ST_SEED;
      seed_q <= 31'd0;
      good_q <= 8'd0;
      bad_q  <= 8'd0;
      lock_q <= 1'b0;
      err_q  <= 1'b0;
      wcnt_q <= 32'd0;
      ecnt_q <= 16'd0;
    end else begin
      fsm_q  <= fsm_d;
      seed_q <= seed_d;
      good_q <= good_d;
      bad_q  <= bad_d;
      lock_q <= lock_d;
      err_q  <= err_d;
      wcnt_q <= wcnt_d;
      ecnt_q <= ecnt_d;
    end
  end

  assign bus.lock     = lock_q;
  assign bus.err      = err_q;
  assign bus.word_cnt = wcnt_q;
  assign bus.err_cnt  = ecnt_q;

endmodule
